// File: rtl/add7_pkg.sv
// ---------------------------------------------------------------------------
// add7_pkg
// Shared types and constants for the 7-operand adder driver slice.
//   ADD7_WIDTH        operand/result width of the kernel
//   ADD7_N_OPS        operands per transaction (kernel init_a..init_g)
//   add7_drv_state_t  driver FSM states
//   add7_word_t       one operand/result word
// ---------------------------------------------------------------------------
package add7_pkg;

    localparam int unsigned ADD7_WIDTH = 32;
    localparam int unsigned ADD7_N_OPS = 7;

    typedef enum logic [1:0] {
        COLLECT,
        START,
        WAIT,
        OUTPUT
    } add7_drv_state_t;

    typedef logic [ADD7_WIDTH-1:0] add7_word_t;

endpackage

// File: rtl/add7_operand_buf.sv
// ---------------------------------------------------------------------------
// add7_operand_buf
// N_OPS x WIDTH operand register file feeding the kernel init ports.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low clear of every slot
//   we_i     in   write enable
//   idx_i    in   slot written when we_i is high
//   wdata_i  in   word written
//   data_o   out  packed slots; slot i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module add7_operand_buf
    import add7_pkg::*;
#(
    parameter int unsigned WIDTH = ADD7_WIDTH,
    parameter int unsigned N_OPS = ADD7_N_OPS,
    parameter int unsigned IDX_W = $clog2(N_OPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [N_OPS*WIDTH-1:0]   data_o
);

    logic [N_OPS-1:0][WIDTH-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_OPS; i++) begin
                if (we_i && (idx_i == IDX_W'(i))) begin
                    slot_q[i] <= wdata_i;
                end
            end
        end
    end

    assign data_o = slot_q;

endmodule

// File: rtl/add7_driver.sv
// ---------------------------------------------------------------------------
// add7_driver
// Stream adapter for the 7-operand adder kernel: collects N_OPS operands,
// pulses the kernel start, waits for done, returns the sum on an output
// stream. One transaction in flight.
// Optional feature macro: ADD7_DRIVER_TIMEOUT_EN (WAIT-state watchdog).
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   s_valid   in   operand valid
//   s_ready   out  operand accepted when s_valid && s_ready
//   s_data    in   operand; 1st -> slot 0 (init_a) ... 7th -> slot 6
//   k_init    out  packed operands to kernel
//   k_start   out  kernel r_enable, one-cycle pulse
//   k_done    in   kernel w_enable (sticky level)
//   k_result  in   kernel result
//   m_valid   out  result valid
//   m_ready   in   result consumed when m_valid && m_ready
//   m_data    out  result word
//   m_err     out  watchdog timeout flag, qualified by m_valid
//   busy      out  low only when idle in COLLECT with no operands held
// ---------------------------------------------------------------------------
module add7_driver
    import add7_pkg::*;
#(
    parameter int unsigned WIDTH          = ADD7_WIDTH,
    parameter int unsigned N_OPS          = ADD7_N_OPS,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    output logic [N_OPS*WIDTH-1:0] k_init,
    output logic                   k_start,
    input  logic                   k_done,
    input  logic [WIDTH-1:0]       k_result,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_err,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(N_OPS);

    // The watchdog counter is 16 bits wide; reject limits it cannot reach.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("add7_driver: TIMEOUT_CYCLES out of range");
    end

    add7_drv_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  m_data_q, m_data_d;
    logic              buf_we;

`ifdef ADD7_DRIVER_TIMEOUT_EN
    logic              m_err_q, m_err_d;
    logic [15:0]       wcnt_q, wcnt_d;
`endif

    add7_operand_buf #(
        .WIDTH (WIDTH),
        .N_OPS (N_OPS),
        .IDX_W (CNT_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (buf_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .data_o  (k_init)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            m_data_q <= '0;
`ifdef ADD7_DRIVER_TIMEOUT_EN
            m_err_q  <= 1'b0;
            wcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
`ifdef ADD7_DRIVER_TIMEOUT_EN
            m_err_q  <= m_err_d;
            wcnt_q   <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        buf_we   = 1'b0;
`ifdef ADD7_DRIVER_TIMEOUT_EN
        m_err_d  = m_err_q;
        wcnt_d   = wcnt_q;
`endif
        case (state_q)
            COLLECT: begin
                // k_done is deliberately not looked at: it is stale here.
                if (s_valid) begin
                    buf_we = 1'b1;
                    if (cnt_q == CNT_W'(N_OPS - 1)) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
`ifdef ADD7_DRIVER_TIMEOUT_EN
                wcnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // Kernel drops done on the start edge, so this is fresh.
                if (k_done) begin
                    m_data_d = k_result;
`ifdef ADD7_DRIVER_TIMEOUT_EN
                    m_err_d  = 1'b0;
`endif
                    state_d  = OUTPUT;
                end
`ifdef ADD7_DRIVER_TIMEOUT_EN
                else if (wcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    m_data_d = '0;
                    m_err_d  = 1'b1;
                    state_d  = OUTPUT;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
`endif
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // rst_n gates s_ready so it reads 0 while reset is held.
    assign s_ready = rst_n && (state_q == COLLECT);
    assign k_start = (state_q == START);
    assign m_valid = (state_q == OUTPUT);
    assign m_data  = m_data_q;
    assign busy    = !((state_q == COLLECT) && (cnt_q == '0));
`ifdef ADD7_DRIVER_TIMEOUT_EN
    assign m_err   = m_err_q;
`else
    assign m_err   = 1'b0;
`endif

endmodule

// File: tb/tb_add7_driver.sv
module tb_add7_driver;

    localparam int W = 32;
    localparam int N = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic [N*W-1:0]   k_init;
    logic             k_start;
    logic             k_done = 1'b0;
    logic [W-1:0]     k_result = '0;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             m_err;
    logic             busy;

    int n_pass = 0;
    int n_chk  = 0;
    int n_starts = 0;

    logic [W-1:0] txn_ops [N];

    add7_driver #(
        .WIDTH          (W),
        .N_OPS          (N),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .k_init   (k_init),
        .k_start  (k_start),
        .k_done   (k_done),
        .k_result (k_result),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_err    (m_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Kernel stand-in: no reset, clears done on start, sum ready 9 cycles later.
    logic         kernel_dead = 1'b0;
    int           lat_cnt = 0;
    logic [63:0]  ksum;

    always @(posedge clk) begin
        if (k_start) begin
            n_starts = n_starts + 1;
            k_done <= 1'b0;
            ksum = 0;
            for (int i = 0; i < N; i++) ksum = ksum + 64'(k_init[i*W +: W]);
            k_result <= ksum[W-1:0];
            lat_cnt = 9;
        end else if (lat_cnt > 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0 && !kernel_dead) k_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] model_sum();
        longint unsigned s = 0;
        for (int i = 0; i < N; i++) s += longint'(txn_ops[i]);
        return W'(s % 64'h1_0000_0000);
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic [W-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", 64'(n < 100), 64'd1);
        chk("no_early_result", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = $urandom;
        chk("busy_after_accept", 64'(busy), 64'd1);
        @(negedge clk);
    endtask

    task automatic recv(input logic [W-1:0] exp, input logic exp_err, input int hold);
        int n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid_wait", 64'(n < 200), 64'd1);
        chk("m_data", 64'(m_data), 64'(exp));
        chk("m_err", 64'(m_err), 64'(exp_err));
        chk("s_ready_in_output", 64'(s_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_m_valid", 64'(m_valid), 64'd1);
            chk("hold_m_data", 64'(m_data), 64'(exp));
            chk("hold_s_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("m_valid_drop", 64'(m_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_txn(input logic [W-1:0] exp, input int gap_max, input int hold);
        int s0 = n_starts;
        for (int i = 0; i < N; i++) begin
            send(txn_ops[i]);
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        recv(exp, 1'b0, hold);
        chk("k_start_pulses", 64'(n_starts - s0), 64'd1);
        for (int i = 0; i < N; i++)
            chk("k_init_slot", 64'(k_init[i*W +: W]), 64'(txn_ops[i]));
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_k_start", 64'(k_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_k_init", 64'(k_init != '0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", 64'(s_ready), 64'd1);

        // T1: 1..7 with m_ready already high.
        for (int i = 0; i < N; i++) txn_ops[i] = W'(i + 1);
        m_ready = 1'b1;
        do_txn(32'd28, 0, 0);

        // T2: wrap-around.
        for (int i = 0; i < N; i++) txn_ops[i] = 32'hFFFF_FFFF;
        do_txn(32'hFFFF_FFF9, 0, 0);

        // T3: gaps between operands, consumer stalls 5 cycles.
        for (int i = 0; i < N; i++) txn_ops[i] = $urandom;
        do_txn(model_sum(), 3, 5);

        // T4: stale done from previous run, back-to-back transactions.
        chk("stale_done", 64'(k_done), 64'd1);
        for (int i = 0; i < N; i++) txn_ops[i] = W'(i + 1);
        do_txn(32'd28, 0, 0);
        for (int i = 0; i < N; i++) txn_ops[i] = W'(10 * (i + 1));
        do_txn(32'd280, 0, 0);

        // T5: reset in the middle of collecting.
        for (int i = 0; i < 4; i++) send($urandom);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        chk("midrst_k_init", 64'(k_init != '0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) txn_ops[i] = 32'd2;
        do_txn(32'd14, 0, 0);

        // Randomized transactions against the arithmetic model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) txn_ops[i] = $urandom;
            do_txn(model_sum(), 2, $urandom_range(0, 4));
        end

`ifdef ADD7_DRIVER_TIMEOUT_EN
        // T6: kernel never reports done.
        kernel_dead = 1'b1;
        for (int i = 0; i < N; i++) send($urandom);
        recv(32'd0, 1'b1, 2);
        kernel_dead = 1'b0;
        for (int i = 0; i < N; i++) txn_ops[i] = $urandom;
        do_txn(model_sum(), 1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
